// File: rtl/adc_axis_pkg.sv
// Shared definitions for the ADC AXI-Stream packetizer.
//   - control word bit indices
//   - status word field positions
//   - run-state enumeration
//   - halfword formatting helper: {OTR, zero pad, data}
package adc_axis_pkg;

  localparam int unsigned CTL_EN   = 0;
  localparam int unsigned CTL_PACK = 1;
  localparam int unsigned CTL_CLR  = 2;
  localparam int unsigned CTL_TPAT = 3;

  localparam int unsigned ST_PKT_LSB  = 0;
  localparam int unsigned ST_PKT_MSB  = 15;
  localparam int unsigned ST_DROP_LSB = 16;
  localparam int unsigned ST_DROP_MSB = 30;
  localparam int unsigned ST_OVF_BIT  = 31;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  // Keeps the low 'width' bits of field, zero-pads up to bit 14, OTR in bit 15.
  function automatic logic [15:0] fmt_halfword(input logic        otr,
                                               input logic [14:0] field,
                                               input int unsigned width);
    logic [15:0] hw;
    hw = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (i < width) hw[i] = field[i];
    end
    hw[15] = otr;
    return hw;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered storage, full/empty flags and level count.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   wr_en_i/wr_data_i: write request; accepted when not full or when a read
//                      happens in the same cycle
//   rd_en_i          : pop the head (ignored when empty)
//   rd_data_o        : current head, forced to zero while empty
//   full_o, empty_o, level_o : occupancy
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (level_q == LVL_FULL);
  assign empty_o   = (level_q == '0);
  assign rd_ok     = rd_en_i & ~empty_o;
  // A read frees a slot in the same cycle, so a full FIFO still takes the write.
  assign wr_ok     = wr_en_i & (~full_o | rd_ok);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_axis_packetizer.sv
// ADC capture to AXI-Stream packetizer.
//   m00_axis_aclk/areset : clock, synchronous active-high reset
//   ClockToADC           : divided ADC sample clock (registered)
//   ADCdata              : {OTR, data[ADC_WIDTH-1:0]}
//   control              : [0] enable, [1] pack, [2] clear status, [3] test pattern
//   status               : [31] sticky overflow, [30:16] drops (saturating),
//                          [15:0] packet count
//   m00_axis_*           : AXI-Stream master, PACKET_LEN beats per tlast
module adc_axis_packetizer
  import adc_axis_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 14,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned PACKET_LEN = 256,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 m00_axis_aclk,
  input  logic                 m00_axis_areset,
  output logic                 ClockToADC,
  input  logic [ADC_WIDTH:0]   ADCdata,
  input  logic [3:0]           control,
  output logic [31:0]          status,
  output logic                 m00_axis_tvalid,
  output logic [31:0]          m00_axis_tdata,
  output logic [3:0]           m00_axis_tstrb,
  output logic                 m00_axis_tlast,
  input  logic                 m00_axis_tready
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam int unsigned BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PACKET_LEN - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              clk_adc_q;
  run_state_e        state_q;
  logic              en_prev_q;
  logic              pack_q, tpat_q, phase_q;
  logic [15:0]       pat_q, lo_q;
  logic [31:0]       word_q;
  logic              word_vld_q;
  logic [BEAT_W-1:0] beat_q;
  logic [15:0]       pkt_q;
  logic [14:0]       drop_q;
  logic              ovf_q;

  logic        en, rise, strobe, hs, beat_at_last, drop;
  logic [15:0] halfword;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;

  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign en     = control[CTL_EN];
  assign rise   = en & ~en_prev_q;
  assign strobe = (state_q == RUN_ACTIVE) && (div_q == DIV_LAST);

  assign halfword = tpat_q
    ? fmt_halfword(ADCdata[ADC_WIDTH], pat_q[14:0], 15)
    : fmt_halfword(ADCdata[ADC_WIDTH], 15'(ADCdata[ADC_WIDTH-1:0]), ADC_WIDTH);

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      div_q     <= '0;
      clk_adc_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      clk_adc_q <= (div_d < DIV_HALF);
    end
  end

  // Run-state machine with source select and pair packer.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q    <= RUN_IDLE;
      en_prev_q  <= 1'b0;
      pack_q     <= 1'b0;
      tpat_q     <= 1'b0;
      phase_q    <= 1'b0;
      pat_q      <= '0;
      lo_q       <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      en_prev_q  <= en;
      word_vld_q <= 1'b0;
      if (strobe) begin
        pat_q <= pat_q + 1'b1;
        if (!pack_q) begin
          word_q     <= {16'h0, halfword};
          word_vld_q <= 1'b1;
        end else if (!phase_q) begin
          lo_q    <= halfword;
          phase_q <= 1'b1;
        end else begin
          word_q     <= {halfword, lo_q};
          word_vld_q <= 1'b1;
          phase_q    <= 1'b0;
        end
      end
      case (state_q)
        RUN_IDLE: begin
          if (rise) begin
            state_q <= RUN_ACTIVE;
            pack_q  <= control[CTL_PACK];
            tpat_q  <= control[CTL_TPAT];
            pat_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        RUN_ACTIVE: begin
          // Overrides the packer update above, discarding a half-filled pair.
          if (!en) begin
            state_q <= RUN_IDLE;
            phase_q <= 1'b0;
          end
        end
      endcase
    end
  end

  axis_sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (m00_axis_aclk),
    .rst_i     (m00_axis_areset),
    .wr_en_i   (word_vld_q),
    .wr_data_i (word_q),
    .rd_en_i   (m00_axis_tready),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_unused)
  );

  assign hs           = ~fifo_empty & m00_axis_tready;
  assign beat_at_last = (beat_q == BEAT_LAST);
  // Full with a concurrent read still accepts the word.
  assign drop         = word_vld_q & fifo_full & ~m00_axis_tready;

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      beat_q <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (hs) beat_q <= beat_at_last ? '0 : beat_q + 1'b1;
      if (control[CTL_CLR]) begin
        pkt_q  <= '0;
        drop_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (hs && beat_at_last) pkt_q <= pkt_q + 1'b1;
        if (drop) begin
          ovf_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

  assign ClockToADC      = clk_adc_q;
  assign m00_axis_tvalid = ~fifo_empty;
  assign m00_axis_tdata  = fifo_head;
  assign m00_axis_tstrb  = 4'hF;
  assign m00_axis_tlast  = ~fifo_empty & beat_at_last;

  always_comb begin
    status = '0;
    status[ST_OVF_BIT]                = ovf_q;
    status[ST_DROP_MSB:ST_DROP_LSB]   = drop_q;
    status[ST_PKT_MSB:ST_PKT_LSB]     = pkt_q;
  end

endmodule

// File: tb/tb_adc_axis_packetizer.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations and a random soak.
module tb_adc_axis_packetizer;

  localparam int unsigned ADC_WIDTH  = 14;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned PACKET_LEN = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ClockToADC;
  logic [14:0] ADCdata = '0;
  logic [3:0]  control = '0;
  logic [31:0] status;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready = 1'b0;

  always #5 clk = ~clk;

  adc_axis_packetizer #(
    .ADC_WIDTH(ADC_WIDTH),
    .CLK_DIV(CLK_DIV),
    .PACKET_LEN(PACKET_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .ClockToADC      (ClockToADC),
    .ADCdata         (ADCdata),
    .control         (control),
    .status          (status),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (tready)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT activity", name);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_div, m_pat, m_beat, m_pkt, m_drop, cyc, strobe_cnt;
  bit          m_clk, m_run, m_en_prev, m_pack, m_tpat, m_phase, m_pend, m_ovf;
  bit          m_last_strobe;
  logic [15:0] m_lo;
  logic [31:0] m_pend_word;
  logic [31:0] m_fifo[$];
  bit          mb_hs, mb_strobe, mb_en, mb_pkt_inc, mb_drop;
  logic [15:0] mb_hw;

  function automatic logic [15:0] model_hw(input logic [14:0] bus, input bit tp, input int unsigned pat);
    int unsigned raw, field;
    raw   = bus;
    field = tp ? (pat % 32768) : (raw % (1 << ADC_WIDTH));
    return {bus[ADC_WIDTH], 15'(field)};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_div = 0; m_clk = 0; m_run = 0; m_en_prev = 0; m_pack = 0; m_tpat = 0;
      m_pat = 0; m_phase = 0; m_pend = 0; m_beat = 0; m_pkt = 0; m_drop = 0;
      m_ovf = 0; m_last_strobe = 0;
      m_fifo.delete();
    end else begin
      mb_hs      = (m_fifo.size() != 0) && tready;
      mb_strobe  = m_run && (m_div == CLK_DIV - 1);
      mb_en      = control[0];
      mb_pkt_inc = 0;
      mb_drop    = 0;
      if (mb_hs) begin
        void'(m_fifo.pop_front());
        if (m_beat == PACKET_LEN - 1) begin m_beat = 0; mb_pkt_inc = 1; end
        else m_beat++;
      end
      if (m_pend) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pend_word);
        else mb_drop = 1;
      end
      if (control[2]) begin
        m_ovf = 0; m_drop = 0; m_pkt = 0;
      end else begin
        if (mb_pkt_inc) m_pkt = (m_pkt + 1) % 65536;
        if (mb_drop) begin m_ovf = 1; if (m_drop < 32767) m_drop++; end
      end
      m_pend = 0;
      if (mb_strobe) begin
        strobe_cnt++;
        mb_hw = model_hw(ADCdata, m_tpat, m_pat);
        m_pat = (m_pat + 1) % 65536;
        if (!m_pack) begin
          m_pend = 1; m_pend_word = {16'h0, mb_hw};
        end else if (!m_phase) begin
          m_lo = mb_hw; m_phase = 1;
        end else begin
          m_pend = 1; m_pend_word = {mb_hw, m_lo}; m_phase = 0;
        end
      end
      if (!m_run && mb_en && !m_en_prev) begin
        m_run = 1; m_pack = control[1]; m_tpat = control[3]; m_pat = 0; m_phase = 0;
      end else if (m_run && !mb_en) begin
        m_run = 0; m_phase = 0;
      end
      m_en_prev     = mb_en;
      m_last_strobe = mb_strobe;
      m_div         = (m_div + 1) % CLK_DIV;
      m_clk         = (m_div < CLK_DIV / 2);
    end
  end

  // ---------------- per-cycle compare + observation log ----------------
  bit          exp_v;
  bit          prev_valid;
  int unsigned strobe_iv[$];
  int unsigned vrise_iv[$];
  logic [31:0] cap_data[$];
  bit          cap_last[$];

  always @(negedge clk) begin
    exp_v = (m_fifo.size() != 0);
    check("tvalid", {31'h0, tvalid}, {31'h0, exp_v});
    check("tstrb", {28'h0, tstrb}, 32'hF);
    check("status", status, {m_ovf, 15'(m_drop), 16'(m_pkt)});
    check("ClockToADC", {31'h0, ClockToADC}, {31'h0, m_clk});
    if (exp_v) begin
      check("tdata", tdata, m_fifo[0]);
      check("tlast", {31'h0, tlast}, {31'h0, (m_beat == PACKET_LEN - 1)});
    end
    if (m_run && m_div == CLK_DIV - 1) strobe_iv.push_back(cyc);
    if (tvalid && !prev_valid) vrise_iv.push_back(cyc);
    prev_valid = tvalid;
    if (tvalid && tready && !rst) begin
      cap_data.push_back(tdata);
      cap_last.push_back(tlast);
    end
  end

  // ---------------- stimulus ----------------
  bit          ramp_on = 0;
  bit          adc_otr = 0;
  logic [13:0] adc_val = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on && m_last_strobe) adc_val = adc_val + 1'b1;
    ADCdata = {adc_otr, adc_val};
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; control = '0; tready = 0;
    ticks(2);
    rst = 0;
    tick();
  endtask

  task automatic wait_beats(input int unsigned target, input string name);
    int unsigned t;
    t = 0;
    while (cap_data.size() < target && t < 3000) begin tick(); t++; end
    if (cap_data.size() < target) timeout_fail(name);
  endtask

  task automatic wait_strobes(input int unsigned n, input string name);
    int unsigned start, t;
    start = strobe_cnt; t = 0;
    while (strobe_cnt - start < n && t < 3000) begin tick(); t++; end
    if (strobe_cnt - start < n) timeout_fail(name);
  endtask

  function automatic logic [31:0] cap_at(input int unsigned idx);
    return (idx < cap_data.size()) ? cap_data[idx] : 32'hDEAD_BEEF;
  endfunction

  function automatic bit last_at(input int unsigned idx);
    return (idx < cap_last.size()) ? cap_last[idx] : 1'b0;
  endfunction

  initial begin
    int unsigned mc, ms, mv;
    do_reset();
    check("reset_tvalid", {31'h0, tvalid}, 32'h0);
    check("reset_status", status, 32'h0);
    check("reset_tdata", tdata, 32'h0);

    // 1: non-pack ramp, latency and strobe spacing
    adc_val = 0; ramp_on = 1; tready = 1;
    mc = cap_data.size(); ms = strobe_iv.size(); mv = vrise_iv.size();
    control = 4'b0001;
    wait_beats(mc + 3, "t1_beats");
    for (int unsigned k = 0; k < 3; k++) check("t1_data", cap_at(mc + k), k);
    if (strobe_iv.size() > ms + 1 && vrise_iv.size() > mv) begin
      check("t1_latency", vrise_iv[mv] - strobe_iv[ms], 2);
      check("t1_spacing", strobe_iv[ms + 1] - strobe_iv[ms], CLK_DIV);
    end else timeout_fail("t1_timing");

    // 2: pack mode, ramp from 5, packet framing
    do_reset();
    adc_val = 5; tready = 1;
    mc = cap_data.size();
    control = 4'b0011;
    wait_beats(mc + 8, "t2_beats");
    tick();
    check("t2_beat0", cap_at(mc), 32'h0006_0005);
    check("t2_beat1", cap_at(mc + 1), 32'h0008_0007);
    check("t2_last7", {31'h0, last_at(mc + 6)}, 32'h0);
    check("t2_last8", {31'h0, last_at(mc + 7)}, 32'h1);
    check("t2_pktcnt", {16'h0, status[15:0]}, 32'h1);

    // 3: overflow with stalled sink, then ordered drain
    do_reset();
    adc_val = 0; tready = 0;
    control = 4'b0001;
    wait_strobes(20, "t3_strobes");
    control = 4'b0000;
    ticks(4);
    check("t3_ovf", {31'h0, status[31]}, 32'h1);
    check("t3_drops", {17'h0, status[30:16]}, 32'd4);
    mc = cap_data.size();
    tready = 1;
    wait_beats(mc + 16, "t3_drain");
    ticks(6);
    for (int unsigned k = 0; k < 16; k++) check("t3_order", cap_at(mc + k), k);
    check("t3_count", cap_data.size() - mc, 16);

    // 4: half pair discarded across a disable
    do_reset();
    adc_val = 14'h100; tready = 1;
    mc = cap_data.size();
    control = 4'b0011;
    wait_strobes(3, "t4_strobes");
    control = 4'b0000;
    ticks(6);
    control = 4'b0011;
    wait_beats(mc + 2, "t4_beats");
    check("t4_beat0", cap_at(mc), 32'h0101_0100);
    check("t4_beat1", cap_at(mc + 1), 32'h0104_0103);

    // 5: test pattern with OTR high, status clear
    do_reset();
    ramp_on = 0; adc_otr = 1; adc_val = 14'h0ABC; tready = 1;
    mc = cap_data.size();
    control = 4'b1001;
    wait_beats(mc + 8, "t5_beats");
    tick();
    check("t5_beat0", cap_at(mc), 32'h0000_8000);
    check("t5_beat1", cap_at(mc + 1), 32'h0000_8001);
    check("t5_last", {31'h0, last_at(mc + 7)}, 32'h1);
    control = 4'b0000;
    ticks(10);
    check("t5_pre_clr", status, 32'h0000_0001);
    control = 4'b0100;
    tick();
    control = 4'b0000;
    check("t5_clr", status, 32'h0);
    adc_otr = 0;

    // 6: reset mid-packet, fresh framing afterwards
    do_reset();
    ramp_on = 1; adc_val = 14'h20; tready = 1;
    mc = cap_data.size();
    control = 4'b0001;
    wait_beats(mc + 3, "t6_pre");
    rst = 1; control = 4'b0000;
    tick();
    check("t6_rst_tvalid", {31'h0, tvalid}, 32'h0);
    check("t6_rst_tdata", tdata, 32'h0);
    check("t6_rst_tlast", {31'h0, tlast}, 32'h0);
    check("t6_rst_status", status, 32'h0);
    check("t6_rst_clk", {31'h0, ClockToADC}, 32'h0);
    rst = 0;
    ticks(2);
    mc = cap_data.size();
    control = 4'b0001;
    wait_beats(mc + 8, "t6_post");
    for (int unsigned k = 0; k < 8; k++)
      check("t6_tlast_pos", {31'h0, last_at(mc + k)}, {31'h0, (k == 7)});

    // Random soak: model comparison every cycle
    do_reset();
    ramp_on = 0;
    for (int unsigned seg = 0; seg < 8; seg++) begin
      int unsigned rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 60 : 95);
      for (int unsigned c = 0; c < 500; c++) begin
        logic [3:0] ctl;
        ctl = control;
        adc_val = 14'($urandom);
        adc_otr = ($urandom_range(0, 7) == 0);
        tready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 149) == 0) ctl[0] = ~ctl[0];
        ctl[1] = ($urandom_range(0, 9) == 0) ? ~ctl[1] : ctl[1];
        ctl[3] = ($urandom_range(0, 9) == 0) ? ~ctl[3] : ctl[3];
        ctl[2] = ($urandom_range(0, 399) == 0);
        control = ctl;
        rst = ($urandom_range(0, 1499) == 0);
        tick();
      end
    end
    rst = 0; control = '0; tready = 1;
    ticks(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/adc_axis_packetizer.md
# adc_axis_packetizer

Parametrised successor to the AD9244 AXI-Stream master. Generates the ADC sample clock, captures each conversion, optionally packs two samples per 32-bit beat, buffers the beats in a FIFO and emits fixed-length AXI-Stream packets framed by `tlast`. Overflow, drop and packet counts are reported on a status word. The block sits between the ADC pins and the AXI DMA S2MM port.

## Interface
- `ADC_WIDTH`, 14: converter data bits, 1..15; the ADC bus carries one extra MSB for the OTR (over-range) flag.
- `CLK_DIV`, 4: aclk cycles per ADC clock period; even, ≥ 2.
- `PACKET_LEN`, 256: beats per packet, ≥ 1.
- `FIFO_DEPTH`, 16: FIFO entries; a power of 2, ≥ 4.

Ports:
- `m00_axis_aclk`  in  1  sole clock.
- `m00_axis_areset`  in  1  synchronous, active-high reset.
- `ClockToADC`  out  1  ADC sample clock.
- `ADCdata`  in  ADC_WIDTH+1  {OTR, data}.
- `control`  in  4  [0] enable, [1] pack mode, [2] clear status, [3] test-pattern source.
- `status`  out  32  [31] sticky overflow, [30:16] dropped-word count, [15:0] packet count.
- `m00_axis_tvalid`  out  1  AXIS valid.
- `m00_axis_tdata`  out  32  AXIS data.
- `m00_axis_tstrb`  out  4  Constant 4'hF.
- `m00_axis_tlast`  out  1  Last beat of a packet.
- `m00_axis_tready`  in  1  AXIS ready.

## Operation
- **Divider.** Counter `div` runs 0..CLK_DIV-1 continuously, including while disabled. `ClockToADC` is a register, high while `div < CLK_DIV/2`. The sample strobe fires in the cycle where `div == CLK_DIV-1` and the run state is active.
- **Halfword format.** {OTR, zero pad, data[ADC_WIDTH-1:0]}, 16 bits.
- **Test-pattern source.** When `control[3]` is set, the data field is a 16-bit counter instead of the ADC. The counter increments per strobe, wraps at 0xFFFF and resets to 0 at each run start.
- **Run states.** IDLE and RUN.
  - IDLE → RUN on a rising edge of `control[0]`. `control[1]` and `control[3]` are latched at that edge; later changes are ignored until the next run.
  - RUN → IDLE when `control[0]` is low. A half-filled pack register is discarded.
- **Non-pack mode.** Each strobe produces the word {16'h0, halfword}.
- **Pack mode.**
  - The first strobe of a pair fills [15:0]; the second fills [31:16] and produces the word.
  - The pair phase resets at run start.
- **FIFO.** A produced word is written if the FIFO is not full. Otherwise it is dropped: set `status[31]` and increment the drop count, which saturates at 0x7FFF.
- **Output.**
  - `tvalid` = FIFO not empty; `tdata` = FIFO head.
  - The beat counter increments on each `tvalid & tready`.
  - `tlast` is high when the beat counter equals PACKET_LEN-1. On that handshake the counter returns to 0 and the packet count increments, wrapping at 16 bits.
  - Leaving RUN does not reset the beat counter or flush the FIFO; buffered words drain normally.
- **Clear status.** While `control[2]` is high, `status` fields are held at 0; clear takes priority over a same-cycle increment.

## Timing
- **Reset values.** Every output is 0: `ClockToADC`, `tvalid`, `tdata`, `tlast`, `status`. The exception is `tstrb`, which is always 4'hF. Reset also zeroes `div`, the beat counter, the FIFO pointers and the pattern counter, and sets the state to IDLE.
- **Reset mid-packet.** The partial packet is abandoned and the FIFO contents are lost.
- **Latency.** From a strobe in cycle S with the FIFO empty, the word is written at the end of S+1 and `tvalid` is high in S+2. `tdata` and `tlast` stay stable while `tvalid & !tready`.
- **Full + read.** A write and a read in the same cycle on a full FIFO is accepted; nothing is dropped.
- **Empty.** With the FIFO empty, `tvalid` is low regardless of `tready`.
- **Throughput.** Maximum is one beat per CLK_DIV cycles in non-pack mode and one beat per 2·CLK_DIV cycles in pack mode.

## Structure
- **Package `adc_axis_pkg`.**
  - Control bit indices: CTL_EN, CTL_PACK, CTL_CLR, CTL_TPAT.
  - Status field LSB/MSB constants.
  - Run-state enum.
  - Halfword-format function.
- **Sub-module `axis_sync_fifo`.** Parameters WIDTH and DEPTH. Single clock, registered head, with full/empty flags and a level count. The top level holds the divider, source mux, packer, counters and framing.

## Test plan
1. CLK_DIV=4, no pack, ramp ADC 0,1,2…, `tready`=1 → strobes every 4 cycles. `tdata` = 0x00000000, 0x00000001…, each 2 cycles after its strobe.
2. Pack mode, ADC ramp starting at 5 → first beat 0x00060005, second 0x00080007. With PACKET_LEN=8, `tlast` is asserted on beat 8 and `status[15:0]`=1.
3. FIFO_DEPTH=16, `tready`=0 for 20 strobes → 16 words are held. `status[31]`=1 and `status[30:16]`=4. Raising `tready` drains exactly the first 16 samples, in order.
4. Deassert enable after the odd (first) sample of a pair in pack mode, then re-enable → the half word is discarded. The next beat holds the first two samples taken after re-enable.
5. Test pattern with OTR forced high, ADC_WIDTH=14 → `tdata[15]`=1 and bits [14:0] come from the counter. Asserting `control[2]` for 1 cycle zeroes `status`.
6. Assert reset mid-packet (beat 3 of 8) → all outputs are 0 next cycle. After release and re-enable, the next `tlast` falls on beat 8 of the new stream.
